// File: rtl/bsg_mem_1r1w.sv
// Register-array memory with one synchronous write port and one asynchronous read port.
// Used as the entry store behind relay FIFOs; contents are never reset.
module bsg_mem_1r1w #(
   parameter int width_p                = 64,
   parameter int els_p                  = 4,
   parameter int read_write_same_addr_p = 0,
   localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     w_clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge w_clk_i) begin
      if (w_v_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = r_v_i ? mem_q[r_addr_i] : '0;

`ifndef SYNTHESIS
   // Callers that disallow same-address access must never read an entry being written.
   always_ff @(posedge w_clk_i) begin
      if (read_write_same_addr_p == 0) begin
         assert (!(w_v_i && r_v_i && (w_addr_i == r_addr_i)));
      end
   end
`endif

endmodule

// File: rtl/bsg_relay_fifo_deep.sv
// Deep relay FIFO for long links: ready/valid in, valid/ready out, with occupancy count,
// programmable almost-full flag and synchronous flush. Depth need not be a power of two.
module bsg_relay_fifo_deep #(
   parameter int width_p       = 64,
   parameter int els_p         = 4,
   parameter int afull_slack_p = 1,
   localparam int ptr_w_lp     = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int count_w_lp   = $clog2(els_p + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  flush_i,
   input  logic                  v_i,
   input  logic [width_p-1:0]    data_i,
   output logic                  ready_o,
   output logic                  v_o,
   output logic [width_p-1:0]    data_o,
   input  logic                  ready_i,
   output logic [count_w_lp-1:0] count_o,
   output logic                  almost_full_o
);

   localparam logic [ptr_w_lp-1:0]   last_ptr_lp     = ptr_w_lp'(els_p - 1);
   localparam logic [count_w_lp-1:0] full_count_lp   = count_w_lp'(els_p);
   localparam logic [count_w_lp-1:0] afull_thresh_lp = count_w_lp'(els_p - afull_slack_p);

   logic [ptr_w_lp-1:0]   head_q, head_d;
   logic [ptr_w_lp-1:0]   tail_q, tail_d;
   logic [count_w_lp-1:0] count_q, count_d;
   logic                  afull_q, afull_d;
   logic                  enq, deq;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
   endfunction

   // Handshake flags come only from the registered count, so no input reaches them combinationally.
   assign ready_o       = (count_q != full_count_lp);
   assign v_o           = (count_q != '0);
   assign enq           = v_i & ready_o;
   assign deq           = v_o & ready_i;
   assign count_o       = count_q;
   assign almost_full_o = afull_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = ptr_inc(tail_q);
         if (deq) head_d = ptr_inc(head_q);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + count_w_lp'(1);
            2'b01:   count_d = count_q - count_w_lp'(1);
            default: count_d = count_q;
         endcase
      end
      // Registering the compare on the next count keeps the flag aligned with count_o.
      afull_d = (count_d >= afull_thresh_lp);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         afull_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         afull_q <= afull_d;
      end
   end

   bsg_mem_1r1w #(
      .width_p               (width_p),
      .els_p                 (els_p),
      .read_write_same_addr_p(0)
   ) mem (
      .w_clk_i (clk_i),
      .w_v_i   (enq & ~flush_i & reset_n_i),
      .w_addr_i(tail_q),
      .w_data_i(data_i),
      .r_v_i   (v_o),
      .r_addr_i(head_q),
      .r_data_o(data_o)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      assert (els_p >= 2);
      assert (afull_slack_p < els_p);
      if (reset_n_i) begin
         assert (count_q <= full_count_lp);
      end
   end
`endif

endmodule
